// File: rtl/fb512_pkg.sv
// fb512_pkg: shared widths, limits and byte-lane order for the 512-wide frame-buffer writer
package fb512_pkg;
  localparam int X_WID   = 12;
  localparam int Y_WID   = 12;
  localparam int FRAME_W = 3;
  localparam int LANE_00 = 0;
  localparam int LANE_01 = 1;
  localparam int LANE_10 = 2;
  localparam int LANE_11 = 3;
  localparam logic [X_WID-1:0] X_STEP = 12'd4;
  localparam logic [X_WID-1:0] X_MAX  = 12'd4092;
  localparam logic [Y_WID-1:0] Y_MAX  = 12'd4095;
  function automatic logic [7:0] lane_byte(input logic [31:0] d, input int n);
    return d[8*n +: 8];
  endfunction
endpackage

// File: rtl/wr_coord_gen_512_frame_sel.sv
// wr_frame_sel: next write-buffer index, rotating mod NUM_FRAMES and skipping the buffer being read
//   i_cur      current write buffer index
//   i_rd_frame buffer index currently owned by the reader
//   o_nxt      buffer index to use for the next frame
module wr_frame_sel
  import fb512_pkg::*;
#(
  parameter int NUM_FRAMES = 3
) (
  input  logic [FRAME_W-1:0] i_cur,
  input  logic [FRAME_W-1:0] i_rd_frame,
  output logic [FRAME_W-1:0] o_nxt
);
  localparam logic [FRAME_W:0] NF = (FRAME_W+1)'(NUM_FRAMES);
  logic [FRAME_W:0] w_c1, w_c2, w_p1, w_p2;
  always_comb begin
    w_c1  = {1'b0, i_cur} + 1'b1;
    w_c2  = {1'b0, i_cur} + 2'd2;
    w_p1  = (w_c1 >= NF) ? w_c1 - NF : w_c1;
    w_p2  = (w_c2 >= NF) ? w_c2 - NF : w_c2;
    o_nxt = (w_p1[FRAME_W-1:0] == i_rd_frame) ? w_p2[FRAME_W-1:0] : w_p1[FRAME_W-1:0];
  end
endmodule

// File: rtl/wr_coord_gen_512.sv
// wr_coord_gen_512: turns a RAW8 sensor beat stream into windowed frame-buffer write coordinates
//   p_clk, rstn               clock, synchronous active-low reset
//   x_start/x_win/y_start/y_win crop window (x in pixels, multiples of 4)
//   in_vs/in_hs/in_valid      frame strobe, line-active strobe, beat valid
//   in_data                   4 RAW8 pixels, byte 0 leftmost
//   in_rd_frame               buffer the reader holds; never selected for writing
//   out_x_wr/out_y_wr         raw beat coordinates
//   out_wr_en/out_hs          windowed write strobe, in_hs delayed one cycle
//   out_frame_cnt             current write buffer index
//   out_wr_00..out_wr_11      write bytes 0..3
//   out_frame_done/out_ovf    last-windowed-beat pulse, sticky overflow
// Macro WR_COORD_TEST_PATTERN_EN replaces the data bytes with (x+n)^y.
module wr_coord_gen_512
  import fb512_pkg::*;
#(
  parameter int NUM_FRAMES = 3
) (
  input  logic               p_clk,
  input  logic               rstn,
  input  logic [X_WID-1:0]   x_start,
  input  logic [X_WID-1:0]   x_win,
  input  logic [Y_WID-1:0]   y_start,
  input  logic [Y_WID-1:0]   y_win,
  input  logic               in_vs,
  input  logic               in_hs,
  input  logic               in_valid,
  input  logic [31:0]        in_data,
  input  logic [FRAME_W-1:0] in_rd_frame,
  output logic [X_WID-1:0]   out_x_wr,
  output logic [Y_WID-1:0]   out_y_wr,
  output logic               out_wr_en,
  output logic               out_hs,
  output logic [FRAME_W-1:0] out_frame_cnt,
  output logic [7:0]         out_wr_00,
  output logic [7:0]         out_wr_01,
  output logic [7:0]         out_wr_10,
  output logic [7:0]         out_wr_11,
  output logic               out_frame_done,
  output logic               out_ovf
);
  logic               r_vs_d, r_hs_d, r_armed, r_full, r_line;
  logic [X_WID-1:0]   r_x;
  logic [Y_WID-1:0]   r_y;
  logic               w_vs_rise, w_hs_rise, w_hs_fall, w_acc, w_full, w_adv, w_drop;
  logic               w_in_win, w_wr, w_done, w_y_end, w_y_ovf, w_full_nxt, w_line_nxt;
  logic [X_WID-1:0]   w_x, w_x_nxt;
  logic [Y_WID-1:0]   w_y, w_y_nxt;
  logic [X_WID:0]     w_x_end;
  logic [Y_WID:0]     w_y_end_c;
  logic [FRAME_W-1:0] w_frame_nxt;
  logic [3:0][7:0]    w_byte;

  wr_frame_sel #(.NUM_FRAMES(NUM_FRAMES)) u_frame_sel (
    .i_cur      (out_frame_cnt),
    .i_rd_frame (in_rd_frame),
    .o_nxt      (w_frame_nxt)
  );

  // A vs edge restarts the frame in the same cycle, so a beat coincident with it lands at (0,0).
  // r_full marks that the 4092 slot has been used; later beats in the line are dropped.
  always_comb begin
    w_vs_rise  = in_vs & ~r_vs_d;
    w_hs_rise  = in_hs & ~r_hs_d;
    w_hs_fall  = ~in_hs & r_hs_d;
    w_acc      = in_valid & in_hs & (r_armed | w_vs_rise);
    w_x        = (w_vs_rise | w_hs_rise) ? '0 : r_x;
    w_y        = w_vs_rise ? '0 : r_y;
    w_full     = r_full & ~(w_vs_rise | w_hs_rise);
    w_adv      = w_acc & ~w_full;
    w_drop     = w_acc & w_full;
    w_x_end    = {1'b0, x_start} + {1'b0, x_win};
    w_y_end_c  = {1'b0, y_start} + {1'b0, y_win};
    w_in_win   = ({1'b0, w_x} >= {1'b0, x_start}) && ({1'b0, w_x} < w_x_end) &&
                 ({1'b0, w_y} >= {1'b0, y_start}) && ({1'b0, w_y} < w_y_end_c);
    w_wr       = w_adv & w_in_win;
    w_done     = w_wr & ({1'b0, w_x} + 13'd4 == w_x_end) & ({1'b0, w_y} + 13'd1 == w_y_end_c);
    w_x_nxt    = (w_adv & (w_x != X_MAX)) ? w_x + X_STEP : w_x;
    w_full_nxt = w_full | (w_adv & (w_x == X_MAX));
    w_y_end    = w_hs_fall & ~w_vs_rise & r_line;
    w_y_ovf    = w_y_end & (r_y == Y_MAX);
    w_y_nxt    = (w_y_end & ~w_y_ovf) ? r_y + 1'b1 : w_y;
    w_line_nxt = w_acc | (r_line & ~w_vs_rise & ~w_hs_fall);
`ifdef WR_COORD_TEST_PATTERN_EN
    for (int n = 0; n < 4; n++) w_byte[n] = (w_x[7:0] + 8'(n)) ^ w_y[7:0];
`else
    w_byte[0] = lane_byte(in_data, LANE_00);
    w_byte[1] = lane_byte(in_data, LANE_01);
    w_byte[2] = lane_byte(in_data, LANE_10);
    w_byte[3] = lane_byte(in_data, LANE_11);
`endif
  end

  always_ff @(posedge p_clk) begin
    if (!rstn) begin
      r_vs_d         <= 1'b0;
      r_hs_d         <= 1'b0;
      r_armed        <= 1'b0;
      r_full         <= 1'b0;
      r_line         <= 1'b0;
      r_x            <= '0;
      r_y            <= '0;
      out_x_wr       <= '0;
      out_y_wr       <= '0;
      out_wr_en      <= 1'b0;
      out_hs         <= 1'b0;
      out_frame_cnt  <= '0;
      out_wr_00      <= '0;
      out_wr_01      <= '0;
      out_wr_10      <= '0;
      out_wr_11      <= '0;
      out_frame_done <= 1'b0;
      out_ovf        <= 1'b0;
    end else begin
      r_vs_d         <= in_vs;
      r_hs_d         <= in_hs;
      r_armed        <= r_armed | w_vs_rise;
      r_full         <= w_full_nxt;
      r_line         <= w_line_nxt;
      r_x            <= w_x_nxt;
      r_y            <= w_y_nxt;
      out_wr_en      <= w_wr;
      out_hs         <= in_hs;
      out_frame_cnt  <= w_vs_rise ? w_frame_nxt : out_frame_cnt;
      out_frame_done <= w_done;
      out_ovf        <= ~w_vs_rise & (out_ovf | w_drop | w_y_ovf);
      if (w_acc) begin
        out_x_wr  <= w_x;
        out_y_wr  <= w_y;
        out_wr_00 <= w_byte[0];
        out_wr_01 <= w_byte[1];
        out_wr_10 <= w_byte[2];
        out_wr_11 <= w_byte[3];
      end
    end
  end
endmodule

// File: doc/wr_coord_gen_512.md
WR_COORD_GEN_512 -- requirements
Module: wr_coord_gen_512

Interface
REQ-001 SHALL have parameter NUM_FRAMES, default 3, giving the number of frame buffers in rotation (legal range 2..8).
REQ-002 SHALL have port p_clk, input, 1 bit: the single clock; one clock, reset is synchronous and active-low.
REQ-003 SHALL have port rstn, input, 1 bit: synchronous active-low reset.
REQ-004 SHALL have ports x_start/x_win and y_start/y_win, input, 12 bits each: crop window in pixels; x values are multiples of 4.
REQ-005 SHALL have ports in_vs, in_hs and in_valid, input, 1 bit each: the sensor frame strobe, the line-active strobe and the beat-valid strobe.
REQ-006 SHALL have port in_data, input, 32 bits: 4 RAW8 pixels per beat, with byte 0 the leftmost pixel.
REQ-007 SHALL have port in_rd_frame, input, 3 bits: the buffer index currently being read, which the writer must avoid.
REQ-008 SHALL have ports out_x_wr and out_y_wr, output, 12 bits each: raw (un-normalised) beat coordinates.
REQ-009 SHALL have ports out_wr_en and out_hs, output, 1 bit each: windowed write strobe and delayed line strobe.
REQ-010 SHALL have port out_frame_cnt, output, 3 bits: the current write buffer index.
REQ-011 SHALL have ports out_wr_00, out_wr_01, out_wr_10 and out_wr_11, output, 8 bits each: in_data bytes 0..3.
REQ-012 SHALL have ports out_frame_done and out_ovf, output, 1 bit each: a one-cycle pulse at the last windowed beat, and a sticky overflow flag.

Function
REQ-013 SHALL register all outputs, giving exactly 1 p_clk latency from an input beat to out_wr_en and its data and coordinates.
REQ-014 SHALL accept a beat only when in_valid && in_hs; any other beat is ignored, with no counter change.
REQ-015 SHALL clear the x counter on the rising edge of in_hs; each accepted beat presents the current x, then adds 4.
REQ-016 SHALL saturate x at 4092; beats beyond that are dropped (out_wr_en=0) and set out_ovf.
REQ-017 SHALL increment y on the falling edge of in_hs only if the line had at least one accepted beat.
REQ-018 SHALL saturate y at 4095; a further line end sets out_ovf.
REQ-019 SHALL, on the rising edge of in_vs, clear x and y and select the next frame index; vs takes priority over a coincident hs edge.
REQ-020 SHALL compute the next frame index as (cur+1) mod NUM_FRAMES, and if that equals in_rd_frame, as (cur+2) mod NUM_FRAMES.
REQ-021 SHALL hold out_frame_cnt constant between vs rising edges.
REQ-022 SHALL assert out_wr_en only for accepted beats with x_start <= x < x_start+x_win and y_start <= y < y_start+y_win, compared at 13-bit width so there is no wrap.
REQ-023 SHALL pulse out_frame_done with the beat at x == x_start+x_win-4 and y == y_start+y_win-1.
REQ-024 SHALL set out_hs = in_hs delayed 1 cycle.
REQ-025 SHALL clear out_ovf only on reset or on a vs rising edge.
REQ-026 SHALL produce no out_wr_en when x_win=0 or y_win=0.

Reset
REQ-027 SHALL, while rstn=0, drive all outputs and counters to 0, including out_frame_cnt=0, and clear the edge-detect history.
REQ-028 SHALL, after reset is released mid-frame, drop beats and generate no strobes until the first vs rising edge.

Configuration
REQ-029 SHALL, when WR_COORD_TEST_PATTERN_EN is defined, replace the data bytes with the pattern: byte n = (x+n)[7:0] xor y[7:0]; timing and strobes are unchanged.
REQ-030 SHALL, when WR_COORD_TEST_PATTERN_EN is undefined, pass in_data bytes through unchanged and contain no pattern logic.

Structure
REQ-031 SHALL take X_WID=12, Y_WID=12, FRAME_W=3 and the byte-lane order constants from shared package fb512_pkg.
REQ-032 SHALL place the frame-index rotation with read-skip in sub-module wr_frame_sel.

Verification
REQ-033 SHALL cover: window 0,0,16,2 with 4 beats/line over 2 lines -> out_wr_en on 8 beats, x=0,4,8,12, and out_frame_done on the 8th beat.
REQ-034 SHALL cover: x_start=8 with 6 beats/line -> out_wr_en only at x=8..20, 1 cycle after the input beat.
REQ-035 SHALL cover: NUM_FRAMES=3, cur=0, in_rd_frame=1 at vs -> out_frame_cnt=2; then in_rd_frame=0 at the next vs -> out_frame_cnt=1.
REQ-036 SHALL cover: 1030 beats in one line -> x stops at 4092, out_ovf=1, which clears at the next vs.
REQ-037 SHALL cover: vs and hs rising in the same cycle -> x=0, y=0, and the frame index advances once.
REQ-038 SHALL cover: rstn low mid-line, then released -> all outputs 0 and no out_wr_en until after the next vs.
